// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with CPU back-pressure
//
// Build option: define UART_TX_FIFO_EN for a 4-entry transmit FIFO; otherwise a
// single holding register is used. Bus and serial behaviour are the same in both builds.
//
// Ports:
//   sys_clk       - sole clock, rising edge
//   reset         - asynchronous, active-low
//   read_enable   - CPU read strobe (a read of the control register clears done)
//   write_enable  - CPU write strobe
//   address       - CPU byte address, exact-match decode against TXD_ADDR / CON_ADDR
//   writedata     - CPU write data (TXD: bits [7:0]; CON: bit 3 = ie)
//   readdata      - combinational read data
//   if_continue   - 0 stalls the CPU while a TXD write cannot be accepted
//   uart_tx       - serial line, idle high
//   tx_irq        - level interrupt, done & ie
module uart_tx_periph #(
  parameter int unsigned BAUD_DIV = 10417,
  parameter logic [31:0] TXD_ADDR = 32'h40000018,
  parameter logic [31:0] CON_ADDR = 32'h40000020
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        if_continue,
  output logic        uart_tx,
  output logic        tx_irq
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIV - 1);

`ifdef UART_TX_FIFO_EN
  localparam int CW = 3;
  localparam logic [CW-1:0] DEPTH = 3'd4;
`else
  localparam int CW = 1;
  localparam logic [CW-1:0] DEPTH = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          done_q;
  logic          ie_q;
  logic [7:0]    last_q;

  logic [CW-1:0] count;
  logic [7:0]    head;
  logic          txd_wr, con_wr, con_rd;
  logic          baud_end, stop_end;
  logic          pop, push;
  logic          full, busy;

  wire unused_wdata = &{1'b0, writedata[31:8]};

  assign txd_wr   = write_enable && (address == TXD_ADDR);
  assign con_wr   = write_enable && (address == CON_ADDR);
  assign con_rd   = read_enable  && (address == CON_ADDR);
  assign baud_end = (baud_q == '0);
  assign stop_end = (state_q == STOP) && baud_end;

  // The shifter takes the head either from idle or straight out of a finishing
  // stop bit, which is what makes consecutive frames back-to-back.
  assign pop  = (count != '0) && ((state_q == IDLE) || stop_end);
  // A full buffer still accepts when its head leaves in the same cycle.
  assign push = txd_wr && ((count != DEPTH) || pop);

  assign full        = (count == DEPTH);
  assign busy        = (state_q != IDLE) || (count != '0);
  assign if_continue = !(txd_wr && !push);
  assign uart_tx     = tx_q;
  assign tx_irq      = done_q & ie_q;

`ifdef UART_TX_FIFO_EN
  logic [7:0]    mem_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    count_d = count_q + {2'b0, push} - {2'b0, pop};
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= writedata[7:0];
  end
`else
  logic [7:0] hold_q;
  logic       valid_q;

  assign head  = hold_q;
  assign count = valid_q;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      hold_q  <= 8'd0;
      valid_q <= 1'b0;
    end else if (push) begin
      hold_q  <= writedata[7:0];
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
      last_q  <= 8'd0;
    end else begin
      if (push)   last_q <= writedata[7:0];
      if (con_wr) ie_q   <= writedata[3];
      // Completion beats a simultaneous status read so an event is never lost.
      if (stop_end)    done_q <= 1'b1;
      else if (con_rd) done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            baud_q  <= BAUD_RELOAD;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= BAUD_RELOAD;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= BAUD_RELOAD;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (pop) begin
              shift_q <= head;
              baud_q  <= BAUD_RELOAD;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (address == CON_ADDR)      readdata = {28'd0, ie_q, done_q, full, busy};
    else if (address == TXD_ADDR) readdata = {24'd0, last_q};
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - scoreboard bench for uart_tx_periph
module tb_uart_tx_periph;

  localparam int BD = 4;
  localparam int FRAME = 10 * BD;
  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] CON = 32'h40000020;
`ifdef UART_TX_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        if_continue;
  logic        uart_tx;
  logic        tx_irq;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int last_start = -1000;
  int last_acc = 0;
  logic [7:0] last_byte = 8'd0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_periph #(.BAUD_DIV(BD), .TXD_ADDR(TXD), .CON_ADDR(CON)) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .read_enable(read_enable),
    .write_enable(write_enable),
    .address(address),
    .writedata(writedata),
    .readdata(readdata),
    .if_continue(if_continue),
    .uart_tx(uart_tx),
    .tx_irq(tx_irq)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Expected frame start: one cycle after acceptance, but never before the
  // previous frame has finished on the line.
  task automatic push(input logic [7:0] b, input int exp_acc);
    int waited;
    write_enable = 1'b1;
    address = TXD;
    writedata = $urandom();
    writedata[7:0] = b;
    waited = 0;
    @(negedge sys_clk);
    while (!if_continue && waited < 300) begin
      @(negedge sys_clk);
      waited++;
    end
    if (!if_continue) begin
      check("push_timeout", 32'(if_continue), 32'd1);
      @(posedge sys_clk); #1;
      write_enable = 1'b0;
      return;
    end
    @(posedge sys_clk); #1;
    write_enable = 1'b0;
    last_acc = cyc;
    if (exp_acc >= 0) check("accept_cycle", last_acc, exp_acc);
    last_byte = b;
    last_start = (last_acc + 1 > last_start + FRAME) ? last_acc + 1 : last_start + FRAME;
    exp_q.push_back('{b, last_start});
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expv, input string name);
    read_enable = 1'b1;
    address = addr;
    @(negedge sys_clk);
    check(name, readdata, expv);
    @(posedge sys_clk); #1;
    read_enable = 1'b0;
  endtask

  task automatic wr_con(input logic [31:0] v);
    write_enable = 1'b1;
    address = CON;
    writedata = v;
    @(posedge sys_clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic idle_to(input int t);
    while (cyc < t) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic drain();
    idle_to(last_start + FRAME + 1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [9:0] cap;
    logic unstable;
    bit aborted;
    int s;
    forever begin
      @(negedge sys_clk);
      if (reset && uart_tx == 1'b0) begin
        s = cyc;
        cap = '0;
        unstable = 1'b0;
        aborted = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge sys_clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
          if (k % BD == 0) cap[k / BD] = uart_tx;
          else if (uart_tx != cap[k / BD]) unstable = 1'b1;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("frame_start", s, e.start);
            check("frame_bits", 32'({unstable, cap}), 32'({1'b0, 1'b1, e.data, 1'b0}));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int s;
    int lows;
    int n;
    int first_start;

    // Reset state.
    repeat (3) @(posedge sys_clk);
    #1;
    write_enable = 1'b1;
    address = TXD;
    #1;
    check("rst_if_continue", 32'(if_continue), 32'd1);
    write_enable = 1'b0;
    read_enable = 1'b1;
    address = CON;
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_tx_irq", 32'(tx_irq), 32'd0);
    check("rst_con", readdata, 32'd0);
    read_enable = 1'b0;
    @(posedge sys_clk); #1;
    reset = 1'b1;
    @(posedge sys_clk); #1;

    // Single frame, status timing around done.
    push(8'h55, -1);
    s = last_start;
    idle_to(s + FRAME - 1);
    rd(CON, 32'h1, "con_busy_in_stop");
    rd(CON, 32'h4, "con_done");
    rd(CON, 32'h0, "con_done_cleared");
    rd(TXD, 32'h55, "txd_last");
    rd(32'h40000000, 32'h0, "other_addr");

    // Fill the buffer, then the next push stalls until the first frame ends.
    push(8'h01, -1);
    s = last_acc;
    for (int i = 1; i <= D; i++) push(8'(i + 1), s + i);
    rd(CON, 32'h3, "con_full_busy");
    push(8'(D + 2), s + 1 + FRAME);
    drain();
    rd(CON, 32'h4, "con_done_after_burst");

    // Interrupt enable, and a status read coinciding with done being set.
    wr_con(32'hFFFF_FFF8);
    rd(CON, 32'h8, "con_ie");
    push(8'hC3, -1);
    s = last_start;
    idle_to(s + FRAME - 1);
    check("irq_before_done", 32'(tx_irq), 32'd0);
    rd(CON, 32'h9, "con_read_on_done_set");
    check("irq_set", 32'(tx_irq), 32'd1);
    rd(CON, 32'hC, "con_done_survives");
    check("irq_cleared", 32'(tx_irq), 32'd0);
    rd(CON, 32'h8, "con_ie_only");
    wr_con(32'h0);

    // Random traffic with random gaps, including back-to-back stalls.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 50)) begin
        @(posedge sys_clk); #1;
      end
      push(8'($urandom_range(0, 255)), -1);
    end
    rd(TXD, 32'(last_byte), "txd_last_random");
    drain();
    rd(CON, 32'h4, "con_done_after_random");

    // Reset in the middle of a frame with bytes still buffered.
    n = (D >= 2) ? 3 : 2;
    for (int i = 0; i < n; i++) begin
      push(8'($urandom_range(0, 255)), -1);
      if (i == 0) first_start = last_start;
    end
    idle_to(first_start + 20);
    reset = 1'b0;
    read_enable = 1'b1;
    address = CON;
    #1;
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_con", readdata, 32'd0);
    check("midrst_irq", 32'(tx_irq), 32'd0);
    check("midrst_if_continue", 32'(if_continue), 32'd1);
    exp_q.delete();
    last_start = -1000;
    repeat (3) @(posedge sys_clk);
    #1;
    reset = 1'b1;
    read_enable = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (!uart_tx) lows++;
    end
    check("no_frame_after_reset", lows, 32'd0);
    @(posedge sys_clk); #1;
    rd(CON, 32'h0, "con_after_reset");
    rd(TXD, 32'h0, "txd_after_reset");

    // Normal operation resumes after reset.
    push(8'hA5, -1);
    drain();
    rd(CON, 32'h4, "con_done_final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
